vga_regview: RTL

- Downstream display consumer of the 16-bit pipelined core; drives the board VGA port.
- Renders the 8 architectural registers (16 bits each) and the 6-bit PC as a grid of coloured bit cells on a 640x480@60Hz raster.
- Generates its own pixel enable and sync timing.
- Snapshots register/PC state once per frame, during vertical blanking, so each frame is tear-free.

---
 rtl/vga_regview.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_regview.sv
// -----------------------------------------------------------------------------
// vga_regview
//
// Renders the eight 16-bit architectural registers and the 6-bit PC of the
// pipelined core as a grid of coloured bit cells on a 640x480@60Hz VGA raster.
// Register and PC state is snapshotted once per frame, on the first vertical
// blanking line, so a frame never shows a mixture of old and new values.
//
// Ports:
//   CLK          system clock (100 MHz; one pixel every CLK_DIV cycles)
//   RST          synchronous, active-high reset
//   REGS[127:0]  register file, REGS[16*i+15:16*i] = r_i
//   PC[5:0]      current program counter
//   VGA[6:0]     {HS, VS, R[1:0], G[1:0], B}; syncs are active-low
//   FRAME_START  one-CLK pulse on the pixel tick where h,v become 0,0
//
// Build option:
//   VGA_REGVIEW_GRID_EN  when defined, the first pixel row and column of every
//                        cell are drawn black, leaving 1-px separators.
// -----------------------------------------------------------------------------
module vga_regview #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL     = 32,
    parameter int X0       = 64,
    parameter int Y0       = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] REGS,
    input  logic [5:0]   PC,
    output logic [6:0]   VGA,
    output logic         FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CELL_SH = $clog2(CELL);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [H_W-1:0]   HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0]   VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Colour field {R[1:0], G[1:0], B}
    localparam logic [4:0] C_BLACK  = 5'b00000;
    localparam logic [4:0] C_ZERO   = 5'b00001;  // blue: bit is 0
    localparam logic [4:0] C_REG1   = 5'b00110;  // green: register bit is 1
    localparam logic [4:0] C_PC1    = 5'b11110;  // yellow: PC bit is 1
    localparam logic [6:0] VGA_IDLE = 7'b1100000;

    // ---------------------------------------------------------------------
    // Pixel enable divider
    // ---------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg, div_next;
    logic             pix_en;

    assign pix_en = (div_reg == DIV_LAST);

    always_comb begin
        div_next = div_reg + DIV_W'(1);
        if (pix_en) begin
            div_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end

    // ---------------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------------
    logic [H_W-1:0] h_reg, h_next;
    logic [V_W-1:0] v_reg, v_next;

    always_comb begin
        h_next = h_reg;
        v_next = v_reg;
        if (pix_en) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                v_next = (v_reg == V_LAST) ? '0 : v_reg + V_W'(1);
            end else begin
                h_next = h_reg + H_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_reg <= '0;
            v_reg <= '0;
        end else begin
            h_reg <= h_next;
            v_reg <= v_next;
        end
    end

    // The tick that wraps both counters is the one that starts a new frame.
    assign FRAME_START = pix_en && !RST && (h_reg == H_LAST) && (v_reg == V_LAST);

    // ---------------------------------------------------------------------
    // Per-frame snapshot, taken at the start of the first blanking line
    // ---------------------------------------------------------------------
    logic [127:0] snap_regs_reg;
    logic [5:0]   snap_pc_reg;
    logic         snap_en;

    assign snap_en = pix_en && (h_reg == '0) && (v_reg == V_W'(V_ACTIVE));

    always_ff @(posedge CLK) begin
        if (RST) begin
            snap_regs_reg <= '0;
            snap_pc_reg   <= '0;
        end else if (snap_en) begin
            snap_regs_reg <= REGS;
            snap_pc_reg   <= PC;
        end
    end

    // ---------------------------------------------------------------------
    // Cell decode from the current (already advanced) counter values
    // ---------------------------------------------------------------------
    logic [H_W-1:0] h_off;
    logic [V_W-1:0] v_off;
    logic [3:0]     col_idx;
    logic [3:0]     row_idx;
    logic           active;
    logic           in_x;
    logic           in_y;
    logic           sep;
    logic           hs_n;
    logic           vs_n;
    logic [4:0]     colour_next;

    assign h_off   = h_reg - H_W'(X0);
    assign v_off   = v_reg - V_W'(Y0);
    assign col_idx = h_off[CELL_SH +: 4];
    assign row_idx = v_off[CELL_SH +: 4];
    assign active  = (h_reg < H_W'(H_ACTIVE)) && (v_reg < V_W'(V_ACTIVE));
    assign in_x    = (h_reg >= H_W'(X0)) && ((h_off >> CELL_SH) < H_W'(16));
    assign in_y    = (v_reg >= V_W'(Y0)) && ((v_off >> CELL_SH) < V_W'(9));

`ifdef VGA_REGVIEW_GRID_EN
    // First pixel column or row inside a cell becomes a separator.
    assign sep = (h_off[CELL_SH-1:0] == '0) || (v_off[CELL_SH-1:0] == '0);
`else
    assign sep = 1'b0;
`endif

    assign hs_n = !((h_reg >= HS_FIRST) && (h_reg <= HS_LAST));
    assign vs_n = !((v_reg >= VS_FIRST) && (v_reg <= VS_LAST));

    // Column 0 shows the MSB, so the bit index is the inverted column.
    // Row 8 holds the PC in columns 10..15; for those columns the low three
    // bits of the inverted column run 5..0.
    always_comb begin
        colour_next = C_BLACK;
        if (active && in_x && in_y && !sep) begin
            if (!row_idx[3]) begin
                colour_next = snap_regs_reg[{row_idx[2:0], ~col_idx}] ? C_REG1 : C_ZERO;
            end else if (col_idx >= 4'd10) begin
                colour_next = snap_pc_reg[~col_idx[2:0]] ? C_PC1 : C_ZERO;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output register: sync and colour leave together, one CLK after the
    // counters take their new value.
    // ---------------------------------------------------------------------
    logic [6:0] vga_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vga_reg <= VGA_IDLE;
        end else begin
            vga_reg <= {hs_n, vs_n, colour_next};
        end
    end

    assign VGA = vga_reg;

endmodule
